// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: icache request/response, decode-side head entry and ROB flush.
// The fetch queue drives the master side; icache, decoder and ROB sit on the slave side.
interface inst_fetch_queue_if;
    logic        fetch_req_out;
    logic [31:0] fetch_pc_out;
    logic        icache_valid_in;
    logic [31:0] icache_inst_in;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        issue_ready_in;
    logic        flush_in;
    logic [31:0] flush_pc_in;

    modport master (
        output fetch_req_out, fetch_pc_out, inst_valid_out, inst_out, pc_out,
        input  icache_valid_in, icache_inst_in, issue_ready_in, flush_in, flush_pc_in
    );

    modport slave (
        input  fetch_req_out, fetch_pc_out, inst_valid_out, inst_out, pc_out,
        output icache_valid_in, icache_inst_in, issue_ready_in, flush_in, flush_pc_in
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: one-outstanding icache fetcher with static JAL prediction,
// a circular FIFO of {instruction, pc} entries and a ROB-driven flush.
module inst_fetch_queue #(
    parameter int          QUEUE_ADDR_W = 4,
    parameter int          QUEUE_SIZE   = 16,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    inst_fetch_queue_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    localparam logic [6:0]            OPC_JAL    = 7'b1101111;
    localparam logic [QUEUE_ADDR_W:0] FULL_COUNT = (QUEUE_ADDR_W + 1)'(QUEUE_SIZE);

    state_t                  state_q, state_d;
    logic                    req_q, req_d;
    logic [31:0]             fetch_pc_q, fetch_pc_d;
    logic [31:0]             pc_q, pc_d;
    logic [QUEUE_ADDR_W-1:0] head_q, head_d;
    logic [QUEUE_ADDR_W-1:0] tail_q, tail_d;
    logic [QUEUE_ADDR_W:0]   count_q, count_d;
    logic                    push, pop;
    logic                    head_valid;
    logic                    is_jal;
    logic [31:0]             imm_j;

    logic [31:0] inst_mem [QUEUE_SIZE];
    logic [31:0] pc_mem   [QUEUE_SIZE];

    assign head_valid = (count_q != '0);
    assign is_jal     = (bus.icache_inst_in[6:0] == OPC_JAL);
    assign imm_j      = {{11{bus.icache_inst_in[31]}}, bus.icache_inst_in[31],
                         bus.icache_inst_in[19:12], bus.icache_inst_in[20],
                         bus.icache_inst_in[30:21], 1'b0};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        req_d      = req_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (rdy_in) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!bus.flush_in && count_q < FULL_COUNT) begin
                        req_d      = 1'b1;
                        fetch_pc_d = pc_q;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.flush_in) begin
                        req_d   = 1'b0;
                        state_d = bus.icache_valid_in ? S_IDLE : S_DISCARD;
                    end else if (bus.icache_valid_in) begin
                        push    = 1'b1;
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                        pc_d    = is_jal ? fetch_pc_q + imm_j : fetch_pc_q + 32'd4;
                    end
                end
                S_DISCARD: begin
                    if (bus.icache_valid_in) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            // Flush wins over push, pop and the prediction above.
            if (bus.flush_in) begin
                pc_d    = bus.flush_pc_in;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                pop = head_valid && bus.issue_ready_in;
                if (pop)  head_d = head_q + 1'b1;
                if (push) tail_d = tail_q + 1'b1;
                if (push && !pop)      count_d = count_q + 1'b1;
                else if (pop && !push) count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            fetch_pc_q <= '0;
            pc_q       <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= state_d;
            req_q      <= req_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // NOTE: queue storage has no reset; entries are only read once count marks them valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_mem[tail_q] <= bus.icache_inst_in;
            pc_mem[tail_q]   <= fetch_pc_q;
        end
    end

    assign bus.fetch_req_out  = req_q;
    assign bus.fetch_pc_out   = fetch_pc_q;
    assign bus.inst_valid_out = head_valid;
    assign bus.inst_out       = inst_mem[head_q];
    assign bus.pc_out         = pc_mem[head_q];

endmodule
